// File: rtl/aes_pkg.sv
// Shared AES constants: widths, round constants, key-schedule FSM states and the S-box.
// The S-box table is also used by the SubBytes stage.
package aes_pkg;

  localparam int BYTE   = 8;
  localparam int WORD   = 32;
  localparam int KEY_W  = 128;
  localparam int NR_128 = 10;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESENT = 2'd1,
    EXPAND  = 2'd2
  } ks_state_e;

  localparam logic [BYTE-1:0] SBOX [0:255] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic logic [BYTE-1:0] sbox(input logic [BYTE-1:0] b);
    return SBOX[b];
  endfunction

  // Round constant sits in the top byte; rounds outside 1..10 contribute nothing.
  function automatic logic [WORD-1:0] rcon(input logic [3:0] r);
    case (r)
      4'd1:    return 32'h0100_0000;
      4'd2:    return 32'h0200_0000;
      4'd3:    return 32'h0400_0000;
      4'd4:    return 32'h0800_0000;
      4'd5:    return 32'h1000_0000;
      4'd6:    return 32'h2000_0000;
      4'd7:    return 32'h4000_0000;
      4'd8:    return 32'h8000_0000;
      4'd9:    return 32'h1b00_0000;
      4'd10:   return 32'h3600_0000;
      default: return 32'h0000_0000;
    endcase
  endfunction

endpackage

// File: rtl/aes_key_subword.sv
// Word-0 temp of the AES key schedule: SubWord(RotWord(w3)) ^ Rcon(round).
module aes_key_subword
  import aes_pkg::*;
(
  input  logic [WORD-1:0] w_i,
  input  logic [3:0]      round_i,
  output logic [WORD-1:0] temp_o
);

  logic [WORD-1:0] rot_s;

  assign rot_s  = {w_i[23:0], w_i[31:24]};
  assign temp_o = {sbox(rot_s[31:24]), sbox(rot_s[23:16]),
                   sbox(rot_s[15:8]),  sbox(rot_s[7:0])} ^ rcon(round_i);

endmodule

// File: rtl/aes128_key_sched_ctrl.sv
// Sequential AES-128 key expansion: one schedule word per clock, round keys 0..NR on a valid/ready stream.
// Optional AES_KEYSCHED_PROTO_CHECK_EN adds a sticky proto_err output.
module aes128_key_sched_ctrl
  import aes_pkg::*;
#(
  parameter int NR = NR_128
)
(
  input  logic             Clk,
  input  logic             Rst,
  input  logic             start,
  input  logic [KEY_W-1:0] key_in,
  input  logic             rk_ready,
  output logic             rk_valid,
  output logic [KEY_W-1:0] rk_data,
  output logic [3:0]       rk_round,
  output logic             busy,
  output logic             done
`ifdef AES_KEYSCHED_PROTO_CHECK_EN
  ,
  output logic             proto_err
`endif
);

  localparam logic [3:0] NR_L = 4'(NR);

  ks_state_e        state_q, state_d;
  logic [KEY_W-1:0] key_q, key_d;
  logic [3:0]       round_q, round_d;
  logic [1:0]       word_cnt_q, word_cnt_d;
  logic             done_q, done_d;
  logic             handshake_s;
  logic [WORD-1:0]  temp_s;

  aes_key_subword u_subword (
    .w_i    (key_q[31:0]),
    .round_i(round_q),
    .temp_o (temp_s)
  );

  assign handshake_s = (state_q == PRESENT) && rk_ready;

  always_comb begin
    state_d    = state_q;
    key_d      = key_q;
    round_d    = round_q;
    word_cnt_d = word_cnt_q;
    done_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          key_d   = key_in;
          round_d = 4'd0;
          state_d = PRESENT;
        end else begin
          state_d = IDLE;
        end
      end
      PRESENT: begin
        if (handshake_s && (round_q == NR_L)) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else if (handshake_s) begin
          round_d    = round_q + 4'd1;
          word_cnt_d = 2'd0;
          state_d    = EXPAND;
        end else begin
          state_d = PRESENT;
        end
      end
      EXPAND: begin
        // Words are rewritten in place, so w(j-1) in key_q is already the new value.
        case (word_cnt_q)
          2'd0:    key_d[127:96] = key_q[127:96] ^ temp_s;
          2'd1:    key_d[95:64]  = key_q[95:64]  ^ key_q[127:96];
          2'd2:    key_d[63:32]  = key_q[63:32]  ^ key_q[95:64];
          2'd3:    key_d[31:0]   = key_q[31:0]   ^ key_q[63:32];
          default: key_d         = key_q;
        endcase
        word_cnt_d = word_cnt_q + 2'd1;
        if (word_cnt_q == 2'd3) begin
          state_d = PRESENT;
        end else begin
          state_d = EXPAND;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q    <= IDLE;
      key_q      <= '0;
      round_q    <= 4'd0;
      word_cnt_q <= 2'd0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      key_q      <= key_d;
      round_q    <= round_d;
      word_cnt_q <= word_cnt_d;
      done_q     <= done_d;
    end
  end

  assign rk_valid = (state_q == PRESENT);
  assign rk_data  = rk_valid ? key_q : '0;
  assign rk_round = round_q;
  assign busy     = (state_q != IDLE);
  assign done     = done_q;

`ifdef AES_KEYSCHED_PROTO_CHECK_EN
  logic proto_err_q, valid_prev_q, hs_prev_q;

  // Sticky: start while busy, or a valid that vanished without being accepted.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      proto_err_q  <= 1'b0;
      valid_prev_q <= 1'b0;
      hs_prev_q    <= 1'b0;
    end else begin
      if ((start && busy) || (valid_prev_q && !rk_valid && !hs_prev_q)) begin
        proto_err_q <= 1'b1;
      end else begin
        proto_err_q <= proto_err_q;
      end
      valid_prev_q <= rk_valid;
      hs_prev_q    <= handshake_s;
    end
  end

  assign proto_err = proto_err_q;
`endif

endmodule

// File: tb/tb_aes128_key_sched_ctrl.sv
// Self-checking bench: FIPS-197 key expansion model (S-box derived from GF(2^8) arithmetic) plus timing model.
module tb_aes128_key_sched_ctrl;

  logic         Clk = 1'b0;
  logic         Rst = 1'b1;
  logic         start = 1'b0;
  logic [127:0] key_in = '0;
  logic         rk_ready = 1'b0;
  logic         rk_valid;
  logic [127:0] rk_data;
  logic [3:0]   rk_round;
  logic         busy;
  logic         done;
`ifdef AES_KEYSCHED_PROTO_CHECK_EN
  logic         proto_err;
`endif

  aes128_key_sched_ctrl dut (
    .Clk      (Clk),
    .Rst      (Rst),
    .start    (start),
    .key_in   (key_in),
    .rk_ready (rk_ready),
    .rk_valid (rk_valid),
    .rk_data  (rk_data),
    .rk_round (rk_round),
    .busy     (busy),
    .done     (done)
`ifdef AES_KEYSCHED_PROTO_CHECK_EN
    ,
    .proto_err(proto_err)
`endif
  );

  always #5 Clk = ~Clk;

  int n_checks = 0;
  int n_errs   = 0;

  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0] tb_sbox [0:255];

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = xt(a);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl1(input logic [7:0] v);
    return {v[6:0], v[7]};
  endfunction

  initial begin
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv, s, r;
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      s = inv;
      r = inv;
      for (int k = 0; k < 4; k++) begin
        r = rotl1(r);
        s = s ^ r;
      end
      tb_sbox[x] = s ^ 8'h63;
    end
  end

  function automatic logic [127:0] round_key(input logic [127:0] k, input int r);
    logic [31:0] w [0:43];
    logic [31:0] t;
    logic [7:0]  rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t  = {t[23:0], t[31:24]};
        t  = {tb_sbox[t[31:24]], tb_sbox[t[23:16]], tb_sbox[t[15:8]], tb_sbox[t[7:0]]} ^ {rc, 24'h000000};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endfunction

  // Model state: expansion active, current round key index, cycle it becomes valid, done cycle.
  bit           m_active = 1'b0;
  int           m_idx = 0;
  int           m_valid_from = 0;
  int           m_done_at = -1;
  logic [127:0] m_key = '0;
  int           cyc = 0;

  // Compare DUT against the model, then advance the model for the coming edge.
  always @(negedge Clk) begin
    bit exp_v;
    cyc++;
    exp_v = m_active && (cyc >= m_valid_from);
    chk("busy", busy, m_active);
    chk("rk_valid", rk_valid, exp_v);
    chk("done", done, cyc == m_done_at);
    if (exp_v) begin
      chk("rk_round", rk_round, m_idx);
      chk("rk_data", rk_data, round_key(m_key, m_idx));
    end
    if (Rst) begin
      m_active  = 1'b0;
      m_done_at = -1;
    end else if (!m_active && start) begin
      m_active     = 1'b1;
      m_idx        = 0;
      m_key        = key_in;
      m_valid_from = cyc + 1;
    end else if (exp_v && rk_ready) begin
      if (m_idx == 10) begin
        m_active  = 1'b0;
        m_done_at = cyc + 1;
      end else begin
        m_idx++;
        m_valid_from = cyc + 5;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_valid"}, rk_valid, 0);
    chk({tag, "_data"}, rk_data, 0);
    chk({tag, "_round"}, rk_round, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
  endtask

  task automatic run_key(input logic [127:0] k, input bit rnd_ready, input int stall_rnd,
                         input int inj_rnd, input int rst_rnd, output int cycles);
    logic [127:0] held_d;
    logic [3:0]   held_r;
    bit           stalled = 1'b0;
    bit           injected = 1'b0;
    int           n;
    key_in = k;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    n = 1;
    cycles = -1;
    while (n < 2000) begin
      if (done) begin
        cycles = n;
        break;
      end
      rk_ready = rnd_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
      if (!stalled && rk_valid && (int'(rk_round) == stall_rnd)) begin
        stalled  = 1'b1;
        held_d   = rk_data;
        held_r   = rk_round;
        rk_ready = 1'b0;
        for (int s = 0; s < 7; s++) begin
          tick();
          n++;
          chk("stall_data", rk_data, held_d);
          chk("stall_round", rk_round, held_r);
          chk("stall_valid", rk_valid, 1);
        end
        rk_ready = 1'b1;
      end else if (!injected && busy && !rk_valid && (int'(rk_round) == inj_rnd)) begin
        injected = 1'b1;
        start    = 1'b1;
        key_in   = ~k;
        tick();
        n++;
        start    = 1'b0;
        key_in   = k;
      end else if (busy && !rk_valid && (int'(rk_round) == rst_rnd)) begin
        Rst = 1'b1;
        tick();
        Rst = 1'b0;
        check_all_zero("mid_rst");
        rk_ready = 1'b0;
        cycles = 0;
        return;
      end else begin
        tick();
        n++;
      end
    end
    if (cycles < 0) begin
      n_checks++;
      n_errs++;
      $display("FAIL timeout: no done after %0d cycles", n);
    end
    rk_ready = 1'b0;
    repeat (2) tick();
  endtask

  initial begin
    int cyc_cnt;
    Rst = 1'b1;
    repeat (3) tick();
    Rst = 1'b0;
    check_all_zero("reset");

    chk("pin_fips_r0",  round_key(FIPS_KEY, 0),  128'h2b7e151628aed2a6abf7158809cf4f3c);
    chk("pin_fips_r1",  round_key(FIPS_KEY, 1),  128'ha0fafe1788542cb123a339392a6c7605);
    chk("pin_fips_r2",  round_key(FIPS_KEY, 2),  128'hf2c295f27a96b9435935807a7359f67f);
    chk("pin_fips_r10", round_key(FIPS_KEY, 10), 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    chk("pin_zero_r1",  round_key(128'h0, 1),    128'h62636363626363636263636362636363);
    chk("pin_zero_r10", round_key(128'h0, 10),   128'hb4ef5bcb3e92e21123e951cf6f8f188e);

    run_key(FIPS_KEY, 1'b0, -1, -1, -1, cyc_cnt);
    chk("start_to_done", cyc_cnt, 52);
    chk("idle_busy", busy, 0);

    run_key(FIPS_KEY, 1'b0, 3, 4, -1, cyc_cnt);
    chk("stall_run_len", cyc_cnt, 59);
`ifdef AES_KEYSCHED_PROTO_CHECK_EN
    chk("proto_err_set", proto_err, 1);
`endif

    run_key(FIPS_KEY, 1'b0, -1, -1, 6, cyc_cnt);
`ifdef AES_KEYSCHED_PROTO_CHECK_EN
    chk("proto_err_clr", proto_err, 0);
`endif
    repeat (2) tick();
    run_key(FIPS_KEY, 1'b0, -1, -1, -1, cyc_cnt);
    chk("restart_len", cyc_cnt, 52);

    run_key(128'h0, 1'b0, -1, -1, -1, cyc_cnt);
    chk("zero_len", cyc_cnt, 52);

    for (int t = 0; t < 6; t++) begin
      run_key({$urandom, $urandom, $urandom, $urandom}, 1'b1, -1,
              int'($urandom_range(1, 9)), -1, cyc_cnt);
    end

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule

// File: doc/aes128_key_sched_ctrl.md
Name: aes128_key_sched_ctrl

Overview:
Sequential AES-128 key-expansion controller. It drives the round counter into the round-constant lookup and generates one 32-bit key word per clock. It presents each of the 11 round keys (round 0 through 10) on a valid/ready stream for the cipher round datapath. It sits between the key-load interface and the AddRoundKey stage.

Parameters:
NR, 10, number of rounds; the last presented round key index is NR
KEY_W, 128, key and round-key width in bits
WORD, 32, key-schedule word width in bits

Ports:
Clk  input  1  system clock; all state updates on the rising edge
Rst  input  1  synchronous reset, active-high
start  input  1  begin an expansion; sampled in IDLE only
key_in  input  128  cipher key; [127:96] is w0 and [31:0] is w3
rk_ready  input  1  consumer accepts the current round key
rk_valid  output  1  rk_data/rk_round hold a valid round key
rk_data  output  128  current round key, same word order as key_in
rk_round  output  4  index of the round key on rk_data, 0..NR
busy  output  1  high in any state other than IDLE
done  output  1  one-cycle pulse after round key NR is accepted

Behaviour:
- One clock, Clk. Reset is synchronous and active-high (Rst).
- Reset: state=IDLE, key register=0, round=0, word_cnt=0. rk_valid=0, rk_data=0, rk_round=0, busy=0, done=0. Reset mid-expansion aborts immediately; no partial done pulse.
- FSM states: IDLE, PRESENT, EXPAND.
- IDLE:
  - start=1 latches key_in, sets round=0, and moves to PRESENT.
  - rk_valid rises the cycle after start.
- PRESENT:
  - rk_valid=1, rk_data=key register, rk_round=round.
  - Outputs are held stable until rk_valid&&rk_ready. Backpressure is unbounded.
  - On handshake with round==NR: go to IDLE and pulse done for exactly one cycle.
  - On handshake otherwise: round<=round+1, word_cnt<=0, go to EXPAND.
- EXPAND:
  - Lasts 4 cycles, word_cnt 0..3. Each edge rewrites one key word in place.
  - word 0: new w0 = old w0 ^ SubWord(RotWord(old w3)) ^ Rcon(round).
  - word j in 1..3: new wj = old wj ^ new w(j-1).
  - Rcon(r) is 32 bits with the constant in bits [31:24]: 01,02,04,08,10,20,40,80,1B,36 for r=1..10, and 0 otherwise.
  - On word_cnt==3: go to PRESENT.
  - rk_valid is 0 throughout EXPAND.
- Timing:
  - The accepting edge is followed by 4 EXPAND cycles; rk_valid re-asserts 4 edges after acceptance.
  - With rk_ready tied high, start to done is 52 cycles: 1 + 1 + 10×5.
- start while busy is ignored. key_in is sampled only at the start edge.
- rk_round never exceeds NR and does not wrap.
- Arithmetic: XOR only, with no width growth. RotWord is a left byte-rotate: [23:0],[31:24].

Optional Feature:
Macro AES_KEYSCHED_PROTO_CHECK_EN.
- Defined:
  - Adds output port proto_err (1 bit).
  - proto_err is sticky and set when start=1 while busy=1.
  - proto_err is also set when rk_valid drops without a handshake; this is a self-check.
  - Cleared only by Rst.
- Undefined: the port and its logic are absent, and start-while-busy is silently ignored.

Decomposition:
- Shared package aes_pkg:
  - BYTE=8, WORD=32, KEY_W=128, NR_128=10.
  - The Rcon constant table.
  - The state enum (IDLE/PRESENT/EXPAND).
  - The S-box table, shared with the SubBytes stage.
- Sub-module aes_key_subword: combinational RotWord + 4× S-box + Rcon XOR, producing the word-0 temp value.
- The FSM, counters and key register stay in aes128_key_sched_ctrl.

Test Plan:
- Reset, then start with key 2b7e151628aed2a6abf7158809cf4f3c and rk_ready=1 -> rk_round=0 with rk_data=2b7e1516..., round 1 = a0fafe1788542cb123a339392a6c7605, round 2 = f2c295f27a96b9435935807a7359f67f.
- Same run continued -> round 10 = d014f9a8c9ee2589e13f0cc8b6630ca6; done pulses exactly one cycle, 52 cycles after start; busy returns to 0.
- rk_ready held 0 for 7 cycles at round 3 -> rk_data/rk_round stable for all 7 cycles; later rounds still match FIPS-197.
- start pulsed during EXPAND of round 4 with a different key_in -> ignored; output sequence is unchanged. With AES_KEYSCHED_PROTO_CHECK_EN, proto_err=1 and stays 1 until Rst.
- Rst asserted during round 6 EXPAND -> the next cycle shows all outputs 0 and IDLE; a fresh start reproduces round 0 correctly.
- All-zero key -> round 1 = 62636363626363636263636362636363; round 10 = b4ef5bcb3e92e21123e951cf6f8f188e.
